// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, baud divider
// computation and the default clock/baud constants used by both the
// transmit (tx_BRG) and receive paths.
package uart_pkg;

  localparam int unsigned DEFAULT_CLOCK_FREQ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE  = 115_200;

  // PARITY is only reachable when the receiver is built with parity checking
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Clocks per oversample tick, integer-truncated
  function automatic int unsigned calc_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clock_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/rx_brg.sv
// Receive-side oversampling tick generator.
// Ports: clk, rst (sync, active-high), clr (restart count from 0),
//        tick (high for one clk while the count sits at DIV-1).
module rx_brg #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap at DIV-1; clr re-phases the count to the start-bit edge
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start-edge aligned 16x oversampling,
// mid-bit sampling LSB first, stop-bit check, valid/ready output with
// framing/overrun error pulses.
// Optional build macro RX_PARITY_EN adds a parity bit between data and stop
// (PARITY_ODD selects odd parity); without it parity_err is tied 0.
// Ports: clk, rst (sync, active-high), rx (async line, idles high),
//        rx_data/rx_valid/rx_ready (output handshake), busy (frame in progress),
//        framing_err, overrun_err, parity_err (one-cycle pulses).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
`ifdef RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int unsigned   DIV    = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned   TW     = $clog2(OVERSAMPLE);
  localparam int unsigned   BW     = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  logic                 rx_s, fall, tick, brg_clr;
  rx_state_e            state_q;
  logic [TW-1:0]        tcnt_q;
  logic [BW-1:0]        bcnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 busy_q, done_q, ferr_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, ferr_out_q, oerr_out_q;

  // Two-flop synchroniser plus one history flop for start-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign fall    = prev_q & ~rx_s;
  assign brg_clr = (state_q == ST_IDLE) & fall;

  rx_brg #(.DIV(DIV)) u_brg (
    .clk  (clk),
    .rst  (rst),
    .clr  (brg_clr),
    .tick (tick)
  );

`ifdef RX_PARITY_EN
  logic par_bit_q, par_bad, perr_out_q;
  assign par_bad = (^shift_q) ^ par_bit_q ^ PARITY_ODD;
`endif

  // Frame FSM; done_q/ferr_q flag the stop-sample outcome for delivery
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            tcnt_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tcnt_q == T_HALF) begin
              if (rx_s) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                tcnt_q  <= '0;
                bcnt_q  <= '0;
                state_q <= ST_DATA;
              end
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tcnt_q == T_FULL) begin
              tcnt_q  <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              bcnt_q  <= bcnt_q + BW'(1);
              if (bcnt_q == B_LAST) begin
`ifdef RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
`ifdef RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (tcnt_q == T_FULL) begin
              tcnt_q    <= '0;
              par_bit_q <= rx_s;
              state_q   <= ST_STOP;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (tcnt_q == T_FULL) begin
              tcnt_q  <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
              if (rx_s) begin
                done_q <= 1'b1;
              end else begin
                ferr_q <= 1'b1;
              end
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output holding register; a same-cycle accept frees the slot for the new word
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_out_q <= 1'b0;
      oerr_out_q <= 1'b0;
`ifdef RX_PARITY_EN
      perr_out_q <= 1'b0;
`endif
    end else begin
      ferr_out_q <= ferr_q;
      oerr_out_q <= 1'b0;
`ifdef RX_PARITY_EN
      perr_out_q <= done_q & par_bad;
`endif
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (done_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          oerr_out_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign framing_err = ferr_out_q;
  assign overrun_err = oerr_out_q;
`ifdef RX_PARITY_EN
  assign parity_err  = perr_out_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at default parameters (434 clks/bit nominal).
// Build with RX_PARITY_EN defined to add the parity frame and parity timing.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 434;
`ifdef RX_PARITY_EN
  localparam int unsigned EXP_LAT  = 4108 + 27 * 16;
`else
  localparam int unsigned EXP_LAT  = 4108;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       framing_err;
  logic       overrun_err;
  logic       parity_err;

  uart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  int          n_valid = 0, n_ferr = 0, n_oerr = 0, n_perr = 0;
  int unsigned valid_cyc = 0, edge_cyc = 0;
`ifdef RX_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: each new rx_valid pops one expected word
  initial begin : monitor
    logic       valid_prev;
    logic [7:0] exp_w;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid && !valid_prev) begin
        n_valid++;
        valid_cyc = cyc;
        check("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("sb_rx_data", 32'(rx_data), 32'(exp_w));
        end
      end
      valid_prev = rx_valid;
      if (framing_err) n_ferr++;
      if (overrun_err) n_oerr++;
      if (parity_err)  n_perr++;
    end
  end

  // Drive one frame starting at a negedge; ends after one idle bit time
  task automatic send_frame(input logic [7:0] d, input int bclks, input logic stop_v);
    @(negedge clk);
    rx = 1'b0;
    edge_cyc = cyc;
    repeat (bclks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bclks) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (bclks) @(negedge clk);
`endif
    rx = stop_v;
    repeat (bclks) @(negedge clk);
    rx = 1'b1;
    repeat (bclks) @(negedge clk);
  endtask

  initial begin : watchdog
    #(10 * 120_000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned lat, t0, t_drop;
    logic        saw_busy, dropped;

    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data",  32'(rx_data),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_errs",     32'({framing_err, overrun_err, parity_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: nominal frame, latency from start edge
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, BIT_CLKS, 1'b1);
    lat = valid_cyc - edge_cyc;
    check("t1_valid_count", 32'(n_valid), 32'd1);
    check("t1_latency_window", 32'((lat + 2 >= EXP_LAT) && (lat <= EXP_LAT + 2)), 32'd1);
    check("t1_no_errors", 32'(n_ferr + n_oerr + n_perr), 32'd0);

    // 2: stop bit low, then a good frame
    send_frame(8'h3C, BIT_CLKS, 1'b0);
    check("t2_framing_pulses", 32'(n_ferr), 32'd1);
    check("t2_no_valid", 32'(n_valid), 32'd1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, BIT_CLKS, 1'b1);
    check("t2_next_valid", 32'(n_valid), 32'd2);

    // 3: 100-clk low glitch on idle line is a false start
    saw_busy = 1'b0;
    dropped  = 1'b0;
    t_drop   = 0;
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 400 && !dropped; i++) begin
      @(negedge clk);
      if (i == 99) rx = 1'b1;
      if (busy) saw_busy = 1'b1;
      else if (saw_busy) begin
        dropped = 1'b1;
        t_drop  = cyc;
      end
    end
    check("t3_busy_seen", 32'(saw_busy), 32'd1);
    check("t3_busy_drop_time", 32'(dropped && (t_drop - t0 <= 221) && (t_drop - t0 >= 217)), 32'd1);
    repeat (500) @(negedge clk);
    check("t3_no_valid", 32'(n_valid), 32'd2);
    check("t3_no_errors", 32'(n_ferr + n_oerr + n_perr), 32'd1);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, BIT_CLKS, 1'b1);
    send_frame(8'h22, BIT_CLKS, 1'b1);
    check("t4_valid_held", 32'(rx_valid), 32'd1);
    check("t4_data_held", 32'(rx_data), 32'h11);
    check("t4_overrun_pulses", 32'(n_oerr), 32'd1);
    check("t4_valid_count", 32'(n_valid), 32'd3);
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_valid_cleared", 32'(rx_valid), 32'd0);

    // 5: +/-2.5% baud tolerance
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 423, 1'b1);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 445, 1'b1);
    check("t5_valid_count", 32'(n_valid), 32'd5);
    check("t5_no_framing", 32'(n_ferr), 32'd1);

    // 6: reset in the middle of data bit 4
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i[0] == 1'b0);
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("t6_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid_data", 32'({rx_valid, rx_data}), 32'd0);
    check("t6_rst_errs", 32'({framing_err, overrun_err, parity_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, BIT_CLKS, 1'b1);
    check("t6_valid_count", 32'(n_valid), 32'd6);
    check("t6_err_counts", 32'(n_ferr * 16 + n_oerr), 32'h11);

`ifdef RX_PARITY_EN
    // Even parity expected; send 0x07 with parity bit 0
    par_flip = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, BIT_CLKS, 1'b1);
    par_flip = 1'b0;
    check("par_err_pulses", 32'(n_perr), 32'd1);
    check("par_word_delivered", 32'(rx_data), 32'h07);
    check("par_valid_count", 32'(n_valid), 32'd7);
`else
    check("no_parity_pulses", 32'(n_perr), 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
